// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receive front end.
//   Conditions the raw PS/2 clock/data lines (two-flop synchronizers plus a
//   4-sample glitch filter on the clock), deframes 11-bit device-to-host frames,
//   folds E0/F0 prefix bytes into {ext, break, code} key events and queues them
//   in a first-word-fall-through FIFO for the keyboard translation stage.
// Ports:
//   clk25, reset_n        system clock (25 MHz) and async active-low reset
//   PS2_Clk, PS2_Data     raw asynchronous PS/2 lines
//   ev_code/ev_break/ev_ext  head event fields, valid while ev_valid=1
//   ev_valid              FIFO non-empty
//   ev_rd                 pop request, one event per cycle while high
//   overflow / ovf_clr    sticky drop flag and its clear
//   err_cnt               saturating count of rejected frames
module ps2_scan_rx #(
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ev_valid,
  input  logic       ev_rd,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [7:0] err_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned EV_W  = 10;
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers; reset to the idle-high line level so no false edge.
  // ---------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_Data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock glitch filter: the filtered level follows only after 4 consecutive
  // synchronized samples disagree with it.
  // ---------------------------------------------------------------------------
  logic [1:0] flt_cnt_q, flt_cnt_d;
  logic       clk_flt_q, clk_flt_d;
  logic       strobe_c;

  always_comb begin
    flt_cnt_d = 2'd0;
    clk_flt_d = clk_flt_q;
    if (clk_s2_q != clk_flt_q) begin
      if (flt_cnt_q == 2'd3) begin
        clk_flt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 2'd1;
      end
    end
  end

  // Strobe is the cycle in which the filtered clock is about to fall.
  assign strobe_c = clk_flt_q & ~clk_flt_d;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt_q <= 2'd0;
      clk_flt_q <= 1'b1;
    end else begin
      flt_cnt_q <= flt_cnt_d;
      clk_flt_q <= clk_flt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with inter-strobe timeout.
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            acc_q, acc_d;
  logic            rej_c;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    acc_d     = 1'b0;
    rej_c     = 1'b0;
    to_cnt_d  = (strobe_c || (state_q == S_IDLE)) ? '0 : to_cnt_q + TO_W'(1);

    if ((state_q != S_IDLE) && !strobe_c && (to_cnt_q == TO_W'(TIMEOUT_CYC))) begin
      state_d  = S_IDLE;
      rej_c    = 1'b1;
      to_cnt_d = '0;
    end else if (strobe_c) begin
      case (state_q)
        S_IDLE: begin
          // A high start bit is line noise, not a framing error.
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{par_q, shift_q})) begin
            acc_d = 1'b1;
          end else begin
            rej_c = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder. shift_q still holds the accepted byte while acc_q is high
  // because the FSM sits in IDLE and only shifts in DATA.
  // ---------------------------------------------------------------------------
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;
  logic            push_c;
  logic [EV_W-1:0] push_data_c;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push_c     = 1'b0;
    if (rej_c) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (acc_q) begin
      if (shift_q == BYTE_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == BYTE_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        push_c     = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  assign push_data_c = {ext_pend_q, brk_pend_q, shift_q};

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT event FIFO; pointers carry an extra MSB to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [EV_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             empty_c, full_c, pop_c, wr_en_c, drop_c;
  logic [EV_W-1:0]  head_c;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop_c   = ev_rd & ~empty_c;
  // A pop in the same cycle frees the slot being written, so full is no drop.
  assign wr_en_c = push_c & (~full_c | pop_c);
  assign drop_c  = push_c & full_c & ~pop_c;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_c;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
      end
    end
  end

  assign head_c   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign ev_code  = head_c[7:0];
  assign ev_break = head_c[8];
  assign ev_ext   = head_c[9];
  assign ev_valid = ~empty_c;

  // ---------------------------------------------------------------------------
  // Sticky overflow (set beats clear) and saturating error counter.
  // ---------------------------------------------------------------------------
  logic       ovf_q;
  logic [7:0] err_q;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      err_q <= 8'h00;
    end else begin
      if (drop_c) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (rej_c && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign overflow = ovf_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed bench for ps2_scan_rx. Drives PS/2 frames bit by
// bit on the raw lines and checks events, error count and overflow against
// hand-computed values.
module tb_ps2_scan_rx;

  localparam int unsigned TIMEOUT_CYC = 5000;
  localparam int unsigned HALF        = 20;    // fast PS/2 half period in clk25 cycles
  localparam int unsigned HALF_SLOW   = 1000;  // 12.5 kHz half period

  logic       clk25 = 1'b0;
  logic       reset_n;
  logic       PS2_Clk;
  logic       PS2_Data;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       ev_valid;
  logic       ev_rd;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  ps2_scan_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_AW(2)) dut (
    .clk25    (clk25),
    .reset_n  (reset_n),
    .PS2_Clk  (PS2_Clk),
    .PS2_Data (PS2_Data),
    .ev_code  (ev_code),
    .ev_break (ev_break),
    .ev_ext   (ev_ext),
    .ev_valid (ev_valid),
    .ev_rd    (ev_rd),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .err_cnt  (err_cnt)
  );

  always #20 clk25 = ~clk25;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input int half);
    PS2_Data = b;
    tick(half);
    PS2_Clk = 1'b0;
    tick(half);
    PS2_Clk = 1'b1;
  endtask

  // Start, 8 data bits LSB first, parity (odd, optionally corrupted).
  task automatic send_head(input logic [7:0] b, input logic bad_par, input int half);
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit((~^b) ^ bad_par, half);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_head(b, bad_par, HALF);
    ps2_bit(stop, HALF);
    PS2_Data = 1'b1;
    tick(10);
  endtask

  task automatic pop1;
    ev_rd = 1'b1;
    tick(1);
    ev_rd = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    PS2_Clk  = 1'b1;
    PS2_Data = 1'b1;
    ev_rd    = 1'b0;
    ovf_clr  = 1'b0;
    tick(4);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_code", 32'(ev_code), 32'h00);
    chk("rst_brk_ext", 32'({ev_break, ev_ext}), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    reset_n = 1'b1;
    tick(10);

    // Short low pulses on the clock with data low must not start a frame.
    PS2_Data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PS2_Clk = 1'b0;
      tick(2);
      PS2_Clk = 1'b1;
      tick(10);
    end
    PS2_Data = 1'b1;
    tick(20);
    chk("glitch_valid", 32'(ev_valid), 32'd0);
    chk("glitch_err", 32'(err_cnt), 32'd0);

    // Make code at 12.5 kHz with exact latency from the stop-bit clock fall.
    send_head(8'h1C, 1'b0, HALF_SLOW);
    PS2_Data = 1'b1;
    tick(HALF_SLOW);
    PS2_Clk = 1'b0;
    tick(6);
    chk("make_not_yet", 32'(ev_valid), 32'd0);
    tick(1);
    chk("make_valid", 32'(ev_valid), 32'd1);
    chk("make_code", 32'(ev_code), 32'h1C);
    chk("make_brk_ext", 32'({ev_break, ev_ext}), 32'd0);
    pop1();
    chk("make_popped", 32'(ev_valid), 32'd0);
    ev_rd = 1'b1;  // pops while empty are ignored
    tick(2);
    ev_rd = 1'b0;
    chk("empty_rd", 32'(ev_valid), 32'd0);
    tick(HALF_SLOW - 10);
    PS2_Clk = 1'b1;
    tick(10);

    // Extended break E0 F0 75, then plain 1C.
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("e0_silent", 32'(ev_valid), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("f0_silent", 32'(ev_valid), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("ext_brk_valid", 32'(ev_valid), 32'd1);
    chk("ext_brk_code", 32'(ev_code), 32'h75);
    chk("ext_brk_flags", 32'({ev_ext, ev_break}), 32'b11);
    pop1();
    chk("ext_brk_single", 32'(ev_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("plain_code", 32'(ev_code), 32'h1C);
    chk("plain_flags", 32'({ev_ext, ev_break}), 32'b00);
    pop1();

    // Rejected frames.
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("badpar_valid", 32'(ev_valid), 32'd0);
    chk("badpar_err", 32'(err_cnt), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("badstop_valid", 32'(ev_valid), 32'd0);
    chk("badstop_err", 32'(err_cnt), 32'd2);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b1, HALF);
    ps2_bit(1'b1, HALF);
    PS2_Data = 1'b1;
    tick(TIMEOUT_CYC - 200);
    chk("timeout_pending", 32'(err_cnt), 32'd2);
    tick(400);
    chk("timeout_err", 32'(err_cnt), 32'd3);
    chk("timeout_valid", 32'(ev_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("after_err_code", 32'(ev_code), 32'h1C);
    chk("after_err_flags", 32'({ev_valid, ev_ext, ev_break}), 32'b100);
    pop1();

    // Overflow: five make codes into a four-deep FIFO.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    send_frame(8'h05, 1'b0, 1'b1);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_valid", 32'(ev_valid), 32'd1);
      chk("ovf_code", 32'(ev_code), 32'(i));
      pop1();
    end
    chk("ovf_drained", 32'(ev_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the push cycle: no drop, order kept across wrap.
    for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b1);
    send_head(8'h15, 1'b0, HALF);
    PS2_Data = 1'b1;
    tick(HALF);
    PS2_Clk = 1'b0;
    tick(6);
    chk("pp_head", 32'(ev_code), 32'h11);
    pop1();
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    tick(HALF - 7);
    PS2_Clk = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(ev_code), 32'(8'h12 + i));
      pop1();
    end
    chk("pp_drained", 32'(ev_valid), 32'd0);
    chk("pp_ovf_final", 32'(overflow), 32'd0);

    // Reset mid-frame with a queued event, pending E0 and non-zero err_cnt.
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("pre_rst_valid", 32'(ev_valid), 32'd1);
    ps2_bit(1'b0, HALF);
    ps2_bit(1'b1, HALF);
    ps2_bit(1'b0, HALF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ev_valid), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_code", 32'(ev_code), 32'h00);
    tick(2);
    PS2_Data = 1'b1;
    reset_n  = 1'b1;
    tick(10);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("post_rst_code", 32'(ev_code), 32'h1C);
    chk("post_rst_flags", 32'({ev_valid, ev_ext, ev_break}), 32'b100);
    pop1();
    chk("post_rst_single", 32'(ev_valid), 32'd0);
    chk("post_rst_err", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
